// File: rtl/reg_write_arbiter.sv
// Register-file write port arbiter: core writeback has priority, aux completions
// queue in a 2-entry FIFO and drain in idle cycles, with a forced grant after starvation.
module reg_write_arbiter #(
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              core_wr_req,
   input  logic [1:0]        core_regdst,
   input  logic [4:0]        core_rt,
   input  logic [4:0]        core_rd,
   input  logic [DATA_W-1:0] core_data,
   output logic              core_stall,
   input  logic              aux_valid,
   input  logic [4:0]        aux_addr,
   input  logic [DATA_W-1:0] aux_data,
   output logic              aux_ready,
   output logic              reg_write,
   output logic [4:0]        reg_addr,
   output logic [DATA_W-1:0] reg_data
);

   localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {GR_IDLE, GR_CORE, GR_AUX, GR_FORCE} grant_e;

   logic [1:0]        r_cnt;
   logic              r_kill [2];
   logic [4:0]        r_addr [2];
   logic [DATA_W-1:0] r_data [2];
   logic [3:0]        r_starve;
   logic              r_reg_write;
   logic [4:0]        r_reg_addr;
   logic [DATA_W-1:0] r_reg_data;

   grant_e            w_grant;
   logic [4:0]        w_core_addr;
   logic              w_pop;
   logic              w_push;
   logic              w_kill_hit [2];
   logic [1:0]        w_ncnt;
   logic              w_nkill [2];
   logic [4:0]        w_naddr [2];
   logic [DATA_W-1:0] w_ndata [2];
   logic              w_head_we;

   always_comb begin
      unique case (core_regdst)
         2'b00:   w_core_addr = core_rt;
         2'b01:   w_core_addr = core_rd;
         2'b10:   w_core_addr = 5'd31;
         default: w_core_addr = 5'd29;
      endcase
   end

   // Grant depends only on FIFO state and core_wr_req, so core_stall is a pure state decode.
   always_comb begin
      if (r_cnt != 2'd0 && r_starve == LIM) w_grant = GR_FORCE;
      else if (core_wr_req)                 w_grant = GR_CORE;
      else if (r_cnt != 2'd0)               w_grant = GR_AUX;
      else                                  w_grant = GR_IDLE;
   end

   assign w_pop      = (w_grant == GR_AUX) || (w_grant == GR_FORCE);
   assign core_stall = (w_grant == GR_FORCE);
   assign aux_ready  = reset_n && (r_cnt != 2'd2);
   assign w_push     = aux_valid && aux_ready;
   assign w_head_we  = !r_kill[0] && (r_addr[0] != 5'd0);

   assign w_kill_hit[0] = (w_grant == GR_CORE) && (w_core_addr != 5'd0) &&
                          (r_cnt != 2'd0) && (r_addr[0] == w_core_addr);
   assign w_kill_hit[1] = (w_grant == GR_CORE) && (w_core_addr != 5'd0) &&
                          (r_cnt == 2'd2) && (r_addr[1] == w_core_addr);

   // Kill marks apply to resident entries only; the push slot is written afterwards.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         w_nkill[i] = r_kill[i] | w_kill_hit[i];
         w_naddr[i] = r_addr[i];
         w_ndata[i] = r_data[i];
      end
      w_ncnt = r_cnt;
      if (w_pop) begin
         w_nkill[0] = r_kill[1];
         w_naddr[0] = r_addr[1];
         w_ndata[0] = r_data[1];
         w_nkill[1] = 1'b0;
         w_ncnt     = r_cnt - 2'd1;
      end
      if (w_push) begin
         w_nkill[w_ncnt[0]] = 1'b0;
         w_naddr[w_ncnt[0]] = aux_addr;
         w_ndata[w_ncnt[0]] = aux_data;
         w_ncnt             = w_ncnt + 2'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt       <= 2'd0;
         r_starve    <= 4'd0;
         r_reg_write <= 1'b0;
         r_reg_addr  <= 5'd0;
         r_reg_data  <= '0;
         for (int i = 0; i < 2; i++) begin
            r_kill[i] <= 1'b0;
            r_addr[i] <= 5'd0;
            r_data[i] <= '0;
         end
      end else begin
         r_cnt <= w_ncnt;
         for (int i = 0; i < 2; i++) begin
            r_kill[i] <= w_nkill[i];
            r_addr[i] <= w_naddr[i];
            r_data[i] <= w_ndata[i];
         end

         if (r_cnt == 2'd0 || w_pop) r_starve <= 4'd0;
         else if (r_starve != LIM)   r_starve <= r_starve + 4'd1;

         // Address/data only move on an actual write; suppressed grants hold them.
         unique case (w_grant)
            GR_CORE: begin
               r_reg_write <= (w_core_addr != 5'd0);
               if (w_core_addr != 5'd0) begin
                  r_reg_addr <= w_core_addr;
                  r_reg_data <= core_data;
               end
            end
            GR_AUX, GR_FORCE: begin
               r_reg_write <= w_head_we;
               if (w_head_we) begin
                  r_reg_addr <= r_addr[0];
                  r_reg_data <= r_data[0];
               end
            end
            default: r_reg_write <= 1'b0;
         endcase
      end
   end

   assign reg_write = r_reg_write;
   assign reg_addr  = r_reg_addr;
   assign reg_data  = r_reg_data;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: a queue-based reference model predicts each
// cycle's register write; a negedge monitor pops and compares the DUT outputs.
module tb_reg_write_arbiter;

   localparam int DW     = 32;
   localparam int STARVE = 4;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          core_wr_req = 1'b0;
   logic [1:0]    core_regdst = 2'b00;
   logic [4:0]    core_rt = 5'd0;
   logic [4:0]    core_rd = 5'd0;
   logic [DW-1:0] core_data = '0;
   logic          core_stall;
   logic          aux_valid = 1'b0;
   logic [4:0]    aux_addr = 5'd0;
   logic [DW-1:0] aux_data = '0;
   logic          aux_ready;
   logic          reg_write;
   logic [4:0]    reg_addr;
   logic [DW-1:0] reg_data;

   reg_write_arbiter #(.DATA_W(DW), .STARVE_LIMIT(STARVE)) dut (
      .clock(clock), .reset_n(reset_n),
      .core_wr_req(core_wr_req), .core_regdst(core_regdst),
      .core_rt(core_rt), .core_rd(core_rd), .core_data(core_data),
      .core_stall(core_stall),
      .aux_valid(aux_valid), .aux_addr(aux_addr), .aux_data(aux_data),
      .aux_ready(aux_ready),
      .reg_write(reg_write), .reg_addr(reg_addr), .reg_data(reg_data)
   );

   always #5 clock = ~clock;

   typedef struct {logic kill; logic [4:0] addr; logic [DW-1:0] data;} ent_t;
   typedef struct {logic we; logic [4:0] addr; logic [DW-1:0] data;} exp_t;

   ent_t          mq[$];
   exp_t          sb[$];
   int            m_starve = 0;
   logic          pend_v = 1'b0;
   logic [4:0]    pend_a = 5'd0;
   logic [DW-1:0] pend_d = '0;
   logic          mon_en = 1'b0;
   int            checks = 0;
   int            errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every negedge presents the result of the preceding grant.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (mon_en) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("reg_write", {31'd0, reg_write}, {31'd0, e.we});
               if (e.we) begin
                  chk("reg_addr", {27'd0, reg_addr}, {27'd0, e.addr});
                  chk("reg_data", reg_data, e.data);
               end
            end
         end
      end
   end

   task automatic offer(input logic [4:0] a, input logic [DW-1:0] d);
      pend_v = 1'b1;
      pend_a = a;
      pend_d = d;
   endtask

   function automatic logic [4:0] decode(input logic [1:0] sel, input logic [4:0] rt,
                                         input logic [4:0] rd);
      case (sel)
         2'b00:   return rt;
         2'b01:   return rd;
         2'b10:   return 5'd31;
         default: return 5'd29;
      endcase
   endfunction

   // One clock of stimulus; the model applies the arbitration rules to its queue.
   task automatic step(input logic cr, input logic [1:0] sel, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [DW-1:0] cd);
      exp_t       e;
      ent_t       h;
      logic       force_g, aux_g, ready;
      int         resident;
      logic [4:0] a;
      @(negedge clock);
      #1;
      core_wr_req = cr; core_regdst = sel; core_rt = rt; core_rd = rd; core_data = cd;
      aux_valid = pend_v; aux_addr = pend_a; aux_data = pend_d;
      #1;
      resident = mq.size();
      ready    = (resident < 2);
      force_g  = (resident > 0) && (m_starve == STARVE);
      aux_g    = force_g || (!cr && resident > 0);
      chk("core_stall", {31'd0, core_stall}, {31'd0, force_g});
      chk("aux_ready", {31'd0, aux_ready}, {31'd0, ready});
      e = '{we: 1'b0, addr: 5'd0, data: '0};
      if (aux_g) begin
         h = mq.pop_front();
         e = '{we: (!h.kill && h.addr != 5'd0), addr: h.addr, data: h.data};
      end else if (cr) begin
         a = decode(sel, rt, rd);
         e = '{we: (a != 5'd0), addr: a, data: cd};
         if (a != 5'd0)
            foreach (mq[i]) if (mq[i].addr == a) mq[i].kill = 1'b1;
      end
      if (pend_v && ready) begin
         mq.push_back('{kill: 1'b0, addr: pend_a, data: pend_d});
         pend_v = 1'b0;
      end
      if (resident == 0 || aux_g) m_starve = 0;
      else if (m_starve < STARVE) m_starve++;
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 2'b00, 5'd0, 5'd0, '0);
   endtask

   task automatic do_reset();
      @(negedge clock);
      #1;
      mon_en = 1'b0;
      reset_n = 1'b0;
      sb.delete(); mq.delete(); m_starve = 0; pend_v = 1'b0;
      core_wr_req = 1'b1; core_regdst = 2'b01; core_rd = 5'd9; core_data = 32'h1234;
      aux_valid = 1'b1; aux_addr = 5'd4; aux_data = 32'h55;
      #1;
      chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
      chk("rst_reg_addr", {27'd0, reg_addr}, 32'd0);
      chk("rst_reg_data", reg_data, 32'd0);
      chk("rst_aux_ready", {31'd0, aux_ready}, 32'd0);
      chk("rst_core_stall", {31'd0, core_stall}, 32'd0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         #1;
         chk("rst_hold_we", {31'd0, reg_write}, 32'd0);
      end
      core_wr_req = 1'b0; aux_valid = 1'b0;
      reset_n = 1'b1;
      sb.push_back('{we: 1'b0, addr: 5'd0, data: '0});
      mon_en = 1'b1;
   endtask

   initial begin
      do_reset();

      // Core only, all four destination selects.
      for (int s = 0; s < 4; s++) step(1'b1, 2'(s), 5'd5, 5'd9, 32'hC000_0000 + s);

      // Aux drain with the core idle.
      offer(5'd7, 32'hA5A5_A5A5);
      idle(1);
      offer(5'd8, 32'h1);
      idle(4);

      // Starvation: core saturating the port.
      offer(5'd3, 32'h0000_0033);
      for (int i = 0; i < 9; i++) step(1'b1, 2'b00, 5'd10 + 5'(i), 5'd0, 32'h100 + i);
      idle(2);

      // WAW kill on a resident entry, then an entry pushed alongside the core write.
      offer(5'd12, 32'hDEAD_0012);
      step(1'b1, 2'b01, 5'd0, 5'd20, 32'h20);
      step(1'b1, 2'b01, 5'd0, 5'd12, 32'hC012);
      idle(3);
      offer(5'd12, 32'hBEEF_0012);
      step(1'b1, 2'b01, 5'd0, 5'd12, 32'hC112);
      idle(3);

      // $0 from the core and from aux.
      step(1'b1, 2'b00, 5'd0, 5'd3, 32'hFFFF);
      offer(5'd0, 32'h77);
      idle(3);

      // Three entries while the core is busy.
      for (int n = 0, i = 0; i < 14; i++) begin
         if (!pend_v && n < 3) begin
            offer(5'd16 + 5'(n), 32'hF00 + n);
            n++;
         end
         step(1'b1, 2'b10, 5'd0, 5'd0, 32'h3100 + i);
      end
      idle(4);

      // Reset with the FIFO full.
      for (int i = 0; i < 8 && mq.size() < 2; i++) begin
         if (!pend_v) offer(5'd21 + 5'(i), 32'h2100 + i);
         step(1'b1, 2'b00, 5'd1, 5'd0, 32'h4000 + i);
      end
      chk("model_full_before_reset", 32'(mq.size()), 32'd2);
      do_reset();
      idle(3);

      // Random traffic over a small address set to provoke kills and $0 hits.
      for (int i = 0; i < 800; i++) begin
         if (!pend_v && $urandom_range(0, 2) == 0)
            offer(5'($urandom_range(0, 7)), $urandom);
         step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom);
         if (i == 400) do_reset();
      end
      idle(6);
      @(negedge clock);
      #2;
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Sequencer for the register-file write port. The port is driven through the RegDst-style destination select (rt, rd, $31, $29). It shares the single write port between two sources. The core writeback path always has priority. The auxiliary completion path (multiply/divide and late load returns) is buffered in a 2-entry FIFO and drained in idle cycles, with a starvation guard. It sits between the control unit/datapath writeback stage and the register bank, and it replaces direct RegWrite/RegDst driving of the bank.

## Interface
Parameters:
- DATA_W, 32, write data width.
- STARVE_LIMIT, 4, number of consecutive cycles a non-empty FIFO may be denied before a forced aux grant (legal 1..15).

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- core_wr_req  in  1  core writeback request this cycle.
- core_regdst  in  2  destination select: 00 rt, 01 rd, 10 $31, 11 $29.
- core_rt  in  5  instruction bits [20:16].
- core_rd  in  5  instruction bits [15:11].
- core_data  in  DATA_W  core write data.
- core_stall  out  1  core write not taken this cycle; core must hold its request.
- aux_valid  in  1  auxiliary result offered.
- aux_addr  in  5  auxiliary destination register.
- aux_data  in  DATA_W  auxiliary result.
- aux_ready  out  1  FIFO can accept; a transfer occurs when aux_valid and aux_ready are both high at a clock edge.
- reg_write  out  1  register bank write enable (registered).
- reg_addr  out  5  register bank write address (registered).
- reg_data  out  DATA_W  register bank write data (registered).

## Operation
Core address decode: 00→core_rt, 01→core_rd, 10→5'd31, 11→5'd29.

FIFO:
- 2 entries, each holding {kill, addr, data}; count 0..2.
- aux_ready = (count<2) and not in reset. Push and pop in the same cycle are legal.
- There is no bypass: an aux result always passes through the FIFO, so it takes at least one cycle before grant.

Grant, evaluated each cycle. The grant states are IDLE / CORE / AUX / FORCE_AUX.
- FORCE_AUX if count>0 and starve_cnt==STARVE_LIMIT. The head is popped, core_stall=1, and the core request is not taken.
- else CORE if core_wr_req. core_stall=0.
- else AUX if count>0. The head is popped.
- else IDLE.

starve_cnt:
- Increments when count>0 and the cycle is not an AUX/FORCE_AUX grant.
- Clears on any aux grant and whenever count==0.
- Saturates at STARVE_LIMIT.

WAW kill:
- A taken CORE write to address A≠0 sets kill on every entry resident in the FIFO at the start of that cycle whose addr==A.
- An entry pushed in that same cycle is not killed.
- A granted entry with kill=1 is popped but produces reg_write=0.

$0 rule: any grant whose address is 0 produces reg_write=0. The request is still consumed.

Outputs:
- reg_write/addr/data register the granted write.
- When there is no write, reg_write=0 and reg_addr/reg_data hold their previous values.

## Timing
- Reset (async assert, sync release): reg_write=0, reg_addr=0, reg_data=0, count=0, all kill bits 0, starve_cnt=0, core_stall=0, aux_ready=0 while reset_n low.
- Latency: a grant in cycle N shows on reg_write/reg_addr/reg_data in cycle N+1. An aux push in cycle N is grantable at the earliest in cycle N+1.
- core_stall is combinational from state (count, starve_cnt). It is high only in FORCE_AUX cycles, i.e. at most one cycle in every STARVE_LIMIT+1 while the core is saturating the port.
- Full: count==2 gives aux_ready=0. If the same cycle pops, aux_ready is still 0; the freed slot becomes visible next cycle.
- Reset mid-operation: FIFO contents are discarded, and no write appears after reset_n asserts.

## Test plan
- Core only: core_wr_req=1 with regdst 00/01/10/11, rt=5, rd=9 → next cycle reg_addr 5, 9, 31, 29 in turn; reg_write=1 each cycle; core_stall never high.
- Aux drain: core idle; push (addr 7, 0xA5A5A5A5) then (addr 8, 0x1) → writes to 7 then 8 on consecutive cycles, the first one 2 cycles after the first push; aux_ready=0 only while count==2.
- Starvation (STARVE_LIMIT=4): core_wr_req held high; one aux entry pushed → aux written on the 5th denied cycle; core_stall high exactly that cycle; the core write follows next cycle.
- WAW kill: aux addr 12 queued, core writes regdst 01 with rd=12 → the core write appears; the later pop of entry 12 gives reg_write=0. Repeat with aux pushed in the same cycle as the core write → that aux write occurs.
- $0 and full: core write to rt=0 → reg_write=0. Push 3 entries with core busy → third held until aux_ready=1; no loss and order preserved.
- Reset mid-drain: reset_n low with count==2 → outputs zero immediately; after release reg_write stays 0 and aux_ready=1.
